// File: rtl/axum_ctx_copy_dma.sv
// Bus initiator that saves (RF -> memory) or restores (memory -> RF) registers x1..x31 of one context.
// Optional abort input is compiled in when AXUM_CTX_COPY_ABORT_EN is defined.
module axum_ctx_copy_dma #(
  parameter int unsigned             AddressWidth = 32,
  parameter int unsigned             DataWidth    = 32,
  parameter int unsigned             NumRegFiles  = 4,
  parameter logic [AddressWidth-1:0] RfBaseAddr   = AddressWidth'(32'h0002_0000)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           start_i,
  input  logic                           dir_i,
  input  logic [$clog2(NumRegFiles)-1:0] ctx_i,
  input  logic [AddressWidth-1:0]        mem_addr_i,
`ifdef AXUM_CTX_COPY_ABORT_EN
  input  logic                           abort_i,
`endif
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           err_o,
  output logic [5:0]                     count_o,
  output logic                           bus_req_o,
  input  logic                           bus_gnt_i,
  output logic [AddressWidth-1:0]        bus_addr_o,
  output logic                           bus_we_o,
  output logic [DataWidth/8-1:0]         bus_be_o,
  output logic [DataWidth-1:0]           bus_wdata_o,
  input  logic                           bus_rvalid_i,
  input  logic [DataWidth-1:0]           bus_rdata_i,
  input  logic                           bus_err_i
);

  localparam int unsigned CtxW   = $clog2(NumRegFiles);
  localparam int unsigned IdxW   = 5;
  localparam int unsigned CountW = 6;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(31);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic                    dir_q, dir_d;
  logic [CtxW-1:0]         ctx_q, ctx_d;
  logic [AddressWidth-1:0] base_q, base_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [CountW-1:0]       count_q, count_d;
  logic                    err_q, err_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    req_q, req_d;
  logic                    we_q, we_d;
  logic [AddressWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0]    wdata_q, wdata_d;
`ifdef AXUM_CTX_COPY_ABORT_EN
  logic                    abort_pend_q, abort_pend_d;
`endif

  function automatic logic [AddressWidth-1:0] rf_word_addr(input logic [CtxW-1:0] ctx,
                                                           input logic [IdxW-1:0] idx);
    return RfBaseAddr + (AddressWidth'(ctx) << 7) + (AddressWidth'(idx) << 2);
  endfunction

  function automatic logic [AddressWidth-1:0] mem_word_addr(input logic [AddressWidth-1:0] base,
                                                            input logic [IdxW-1:0]         idx);
    return base + (AddressWidth'(idx) << 2);
  endfunction

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    ctx_d   = ctx_q;
    base_d  = base_q;
    idx_d   = idx_q;
    count_d = count_q;
    err_d   = err_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    req_d   = 1'b0;
    we_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef AXUM_CTX_COPY_ABORT_EN
    abort_pend_d = abort_pend_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          dir_d   = dir_i;
          ctx_d   = ctx_i;
          base_d  = mem_addr_i;
          err_d   = 1'b0;
          count_d = '0;
          idx_d   = IdxW'(1);
          state_d = ST_RD_REQ;
        end
      end
      ST_RD_REQ: if (bus_gnt_i) state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (bus_rvalid_i) begin
          wdata_d = bus_rdata_i;
          if (bus_err_i) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_WR_REQ;
          end
        end
      end
      ST_WR_REQ: if (bus_gnt_i) state_d = ST_WR_WAIT;
      ST_WR_WAIT: begin
        if (bus_rvalid_i) begin
          if (bus_err_i) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            count_d = count_q + CountW'(1);
            if (idx_q == LastIdx) begin
              state_d = ST_DONE;
            end else begin
              idx_d   = idx_q + IdxW'(1);
              state_d = ST_RD_REQ;
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

`ifdef AXUM_CTX_COPY_ABORT_EN
    // An accepted request must still see its response before the engine can stop
    if ((state_q == ST_RD_REQ || state_q == ST_WR_REQ) && abort_i) begin
      if (!bus_gnt_i) begin
        err_d   = 1'b1;
        state_d = ST_DONE;
      end else begin
        abort_pend_d = 1'b1;
      end
    end
    if ((state_q == ST_RD_WAIT || state_q == ST_WR_WAIT) && (abort_i || abort_pend_q)) begin
      abort_pend_d = 1'b1;
      if (bus_rvalid_i) begin
        err_d   = 1'b1;
        count_d = count_q;
        idx_d   = idx_q;
        state_d = ST_DONE;
      end
    end
    if (state_d == ST_DONE || state_d == ST_IDLE) abort_pend_d = 1'b0;
`endif

    req_d  = (state_d == ST_RD_REQ) || (state_d == ST_WR_REQ);
    we_d   = (state_d == ST_WR_REQ);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    if (state_d == ST_RD_REQ) begin
      addr_d = dir_d ? mem_word_addr(base_d, idx_d) : rf_word_addr(ctx_d, idx_d);
    end else if (state_d == ST_WR_REQ) begin
      addr_d = dir_d ? rf_word_addr(ctx_d, idx_d) : mem_word_addr(base_d, idx_d);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      dir_q   <= 1'b0;
      ctx_q   <= '0;
      base_q  <= '0;
      idx_q   <= IdxW'(1);
      count_q <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef AXUM_CTX_COPY_ABORT_EN
      abort_pend_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      ctx_q   <= ctx_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef AXUM_CTX_COPY_ABORT_EN
      abort_pend_q <= abort_pend_d;
`endif
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign count_o     = count_q;
  assign bus_req_o   = req_q;
  assign bus_we_o    = we_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign bus_be_o    = '1;

endmodule

// File: tb/tb_axum_ctx_copy_dma.sv
// Bench for axum_ctx_copy_dma: table of copy operations against a memory/RF responder model,
// with a transaction scoreboard plus hand-written reset-mid-operation sequence.
module tb_axum_ctx_copy_dma;

  localparam logic [31:0] RF_BASE = 32'h0002_0000;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    logic        dir;
    logic [1:0]  ctx;
    logic [31:0] base;
    int          stall;
    int          err_k;
    bit          glitch;
    int          exp_cnt;
    logic        exp_err;
    int          exp_done;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        dir;
  logic [1:0]  ctx;
  logic [31:0] mem_addr;
  logic        busy_o, done_o, err_o;
  logic [5:0]  count_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_gnt, bus_rvalid, bus_err;
  logic [31:0] bus_rdata;

  always #5 clk = ~clk;

  axum_ctx_copy_dma dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .dir_i        (dir),
    .ctx_i        (ctx),
    .mem_addr_i   (mem_addr),
`ifdef AXUM_CTX_COPY_ABORT_EN
    .abort_i      (1'b0),
`endif
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .count_o      (count_o),
    .bus_req_o    (bus_req_o),
    .bus_gnt_i    (bus_gnt),
    .bus_addr_o   (bus_addr_o),
    .bus_we_o     (bus_we_o),
    .bus_be_o     (bus_be_o),
    .bus_wdata_o  (bus_wdata_o),
    .bus_rvalid_i (bus_rvalid),
    .bus_rdata_i  (bus_rdata),
    .bus_err_i    (bus_err)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  txn_t        exp_q[$];
  logic [31:0] rf_model [4][32];
  logic [31:0] mem_model [logic [31:0]];
  int          stall_max = 0;
  int          lat_extra = 0;
  int          hs_count  = 0;
  bit          stray     = 1'b0;
  bit          err_en    = 1'b0;
  logic [31:0] err_addr  = 32'h0;
  logic        last_err  = 1'b0;
  vec_t        vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rf_addr(input logic [1:0] c, input int k);
    return RF_BASE + {23'd0, c, 7'd0} + 32'(k * 4);
  endfunction

  function automatic bit is_rf(input logic [31:0] a);
    return (a >= RF_BASE) && (a < RF_BASE + 32'h200);
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    logic [31:0] off;
    off = a - RF_BASE;
    if (is_rf(a)) return rf_model[off[8:7]][off[6:2]];
    if (mem_model.exists(a)) return mem_model[a];
    return 32'h0;
  endfunction

  task automatic model_wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] off;
    off = a - RF_BASE;
    if (is_rf(a)) rf_model[off[8:7]][off[6:2]] = d;
    else mem_model[a] = d;
  endtask

  // Bus responder: random grant stalls, response a fixed number of cycles after grant
  initial begin : responder
    int          stall_left;
    int          pend_cnt;
    bit          in_req;
    txn_t        snap;
    txn_t        cur;
    logic [31:0] resp_data;
    logic        resp_err;
    stall_left = 0; pend_cnt = 0; in_req = 1'b0; resp_data = '0; resp_err = 1'b0;
    snap = '{32'h0, 1'b0, 32'h0};
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0; bus_err = 1'b0;
    forever begin
      @(negedge clk);
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0; bus_err = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          bus_rvalid = 1'b1; bus_rdata = resp_data; bus_err = resp_err;
        end
      end
      if (!rst_n) begin
        in_req = 1'b0;
      end else if (bus_req_o) begin
        if (stray && !bus_we_o && !bus_rvalid) begin
          bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF; bus_err = 1'b1;
        end
        if (!in_req) begin
          in_req     = 1'b1;
          stall_left = int'($urandom_range(32'(stall_max), 0));
          snap       = '{bus_addr_o, bus_we_o, bus_wdata_o};
        end else begin
          check("stall_addr_stable", bus_addr_o, snap.addr);
          check("stall_we_stable", 32'(bus_we_o), 32'(snap.we));
          check("stall_wdata_stable", bus_wdata_o, snap.wdata);
        end
        if (stall_left > 0) begin
          stall_left--;
        end else begin
          bus_gnt = 1'b1;
          in_req  = 1'b0;
          hs_count++;
          check("be_all_ones", 32'(bus_be_o), 32'hF);
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_txn: got addr 0x%08h we %0d, expected no access",
                     bus_addr_o, bus_we_o);
          end else begin
            cur = exp_q.pop_front();
            check("txn_addr", bus_addr_o, cur.addr);
            check("txn_we", 32'(bus_we_o), 32'(cur.we));
            if (cur.we) check("txn_wdata", bus_wdata_o, cur.wdata);
          end
          if (bus_we_o) begin
            model_wr(bus_addr_o, bus_wdata_o);
            resp_data = '0;
            resp_err  = 1'b0;
          end else begin
            resp_data = model_rd(bus_addr_o);
            resp_err  = err_en && (bus_addr_o == err_addr);
          end
          pend_cnt = 1 + lat_extra;
        end
      end
    end
  end

  task automatic push_expect(input logic d, input logic [1:0] c, input logic [31:0] base,
                             input int err_k);
    logic [31:0] src, dst;
    for (int k = 1; k < 32; k++) begin
      src = d ? base + 32'(k * 4) : rf_addr(c, k);
      dst = d ? rf_addr(c, k) : base + 32'(k * 4);
      if (k == err_k) begin
        err_addr = src;
        exp_q.push_back('{src, 1'b0, 32'h0});
        break;
      end
      exp_q.push_back('{src, 1'b0, 32'h0});
      exp_q.push_back('{dst, 1'b1, model_rd(src)});
    end
  endtask

  task automatic run_op(input vec_t v);
    int t, done_t, pulses, busy_low_t;
    stall_max = v.stall;
    stray     = v.glitch;
    err_en    = (v.err_k != 0);
    push_expect(v.dir, v.ctx, v.base, v.err_k);
    @(negedge clk);
    check("err_held_before_start", 32'(err_o), 32'(last_err));
    start = 1'b1; dir = v.dir; ctx = v.ctx; mem_addr = v.base;
    @(negedge clk);
    start = 1'b0;
    t = 1; done_t = -1; pulses = 0; busy_low_t = -1;
    check("busy_after_start", 32'(busy_o), 32'h1);
    check("err_cleared_by_start", 32'(err_o), 32'h0);
    while (t < 1500) begin
      if (done_o) begin
        pulses++;
        if (done_t < 0) done_t = t;
      end
      if (!busy_o) begin
        busy_low_t = t;
        break;
      end
      @(negedge clk);
      t++;
      start = v.glitch && (t == 7 || t == 60);
      if (start) begin
        dir = ~v.dir; ctx = v.ctx + 2'd1; mem_addr = 32'h0000_9990;
      end
    end
    start = 1'b0;
    check("op_finished", 32'(busy_low_t >= 0), 32'h1);
    check("done_pulses", 32'(pulses), 32'h1);
    if (v.exp_done >= 0) check("done_cycle", 32'(done_t), 32'(v.exp_done));
    check("busy_drop_after_done", 32'(busy_low_t), 32'(done_t + 1));
    check("count_final", 32'(count_o), 32'(v.exp_cnt));
    check("err_final", 32'(err_o), 32'(v.exp_err));
    check("req_idle", 32'(bus_req_o), 32'h0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    exp_q.delete();
    last_err = v.exp_err;
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int t;
    rst_n = 1'b0; start = 1'b0; dir = 1'b0; ctx = '0; mem_addr = '0;
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 32; k++) rf_model[c][k] = 32'hA000_0000 + 32'(k);
    for (int k = 0; k < 32; k++) mem_model[32'h2000 + 32'(k * 4)] = 32'(k * 3);

    //          dir   ctx   base          stall err glitch cnt err   done
    vecs[0] = '{1'b0, 2'd2, 32'h0000_1000, 0,   0,  1'b0,  31, 1'b0, 125};
    vecs[1] = '{1'b1, 2'd1, 32'h0000_2000, 0,   0,  1'b0,  31, 1'b0, 125};
    vecs[2] = '{1'b0, 2'd3, 32'h0000_3000, 5,   0,  1'b0,  31, 1'b0, -1};
    vecs[3] = '{1'b1, 2'd0, 32'h0000_2000, 3,   0,  1'b0,  31, 1'b0, -1};
    vecs[4] = '{1'b0, 2'd2, 32'h0000_4000, 0,   5,  1'b0,  4,  1'b1, 19};
    vecs[5] = '{1'b0, 2'd2, 32'h0000_5000, 2,   0,  1'b1,  31, 1'b0, -1};
    vecs[6] = '{1'b0, 2'd3, 32'hFFFF_FFC0, 0,   0,  1'b0,  31, 1'b0, 125};

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy_o), 32'h0);
    check("rst_done", 32'(done_o), 32'h0);
    check("rst_err", 32'(err_o), 32'h0);
    check("rst_count", 32'(count_o), 32'h0);
    check("rst_req", 32'(bus_req_o), 32'h0);
    check("rst_we", 32'(bus_we_o), 32'h0);
    check("rst_addr", bus_addr_o, 32'h0);
    check("rst_wdata", bus_wdata_o, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_op(vecs[i]);
    check("restore_rf1_x5", rf_model[1][5], 32'd15);
    check("save_mem_wrap", mem_model[32'h0000_003C], 32'hA000_001F);

    // Reset while the write of x10 is outstanding; its late response must be ignored
    stall_max = 0; stray = 1'b0; err_en = 1'b0; lat_extra = 3;
    push_expect(1'b0, 2'd0, 32'h0000_6000, 0);
    @(negedge clk);
    t = hs_count;
    start = 1'b1; dir = 1'b0; ctx = 2'd0; mem_addr = 32'h0000_6000;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 400 && hs_count < t + 20; n++) @(negedge clk);
    check("reached_wr_idx10", 32'(hs_count), 32'(t + 20));
    @(negedge clk);
    check("count_before_rst", 32'(count_o), 32'd9);
    check("busy_before_rst", 32'(busy_o), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_req", 32'(bus_req_o), 32'h0);
    check("async_rst_busy", 32'(busy_o), 32'h0);
    check("async_rst_count", 32'(count_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    repeat (6) @(negedge clk);
    check("post_rst_busy", 32'(busy_o), 32'h0);
    check("post_rst_req", 32'(bus_req_o), 32'h0);
    check("post_rst_count", 32'(count_o), 32'h0);
    check("post_rst_err", 32'(err_o), 32'h0);
    lat_extra = 0;
    last_err  = 1'b0;
    run_op(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axum_ctx_copy_dma.md
Name: axum_ctx_copy_dma

Overview:
- Bus initiator that saves or restores one register-file context between the memory-mapped register-file window and system memory.
- Drives the same req/we/be/addr/wdata and rvalid/rdata/err protocol that the register-file map port responds to; also drives a gnt handshake.
- Sits beside the core as a small master on the data bus. Software or the context switcher triggers it to spill or fill non-active contexts.

Parameters:
- AddressWidth, 32, bus address width
- DataWidth, 32, bus data width (fixed 32 for this block)
- NumRegFiles, 4, number of register-file contexts
- RfBaseAddr, 32'h0002_0000, base address of the register-file map window (1 kB aligned)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  start request, sampled only in IDLE
- dir_i  in  1  0 = save (rf->mem), 1 = restore (mem->rf); sampled with start_i
- ctx_i  in  $clog2(NumRegFiles)  context to copy; sampled with start_i
- mem_addr_i  in  AddressWidth  word-aligned memory buffer base; sampled with start_i
- busy_o  out  1  engine active
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  last operation failed; sticky until next accepted start
- count_o  out  6  words fully copied in current/last operation
- bus_req_o  out  1  request
- bus_gnt_i  in  1  grant
- bus_addr_o  out  AddressWidth  address
- bus_we_o  out  1  write enable
- bus_be_o  out  DataWidth/8  byte enables, always all ones
- bus_wdata_o  out  DataWidth  write data
- bus_rvalid_i  in  1  response valid
- bus_rdata_i  in  DataWidth  read data
- bus_err_i  in  1  response error, qualified by bus_rvalid_i

Behaviour:
- Reset: state IDLE; busy_o, done_o, err_o, bus_req_o, bus_we_o = 0; count_o = 0; index = 1; bus_addr_o and bus_wdata_o = 0.
- Clock and reset: one clock; reset is asynchronous and active-low (clk_i, rst_ni).
- Copies registers x1..x31 (31 words); x0 is never touched.
- Address mapping: RF address = RfBaseAddr + (ctx << 7) + (idx << 2). Memory address = mem_addr_i + (idx << 2).
  - Save: source = RF, destination = memory. Restore: the reverse.
  - Address arithmetic wraps modulo 2^AddressWidth.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE.
- IDLE:
  - start_i=1 latches dir, ctx, mem base; clears err_o; sets count_o=0 and idx=1; goes to RD_REQ.
  - start_i while not in IDLE is ignored.
- RD_REQ: bus_req_o=1, bus_we_o=0, address = source. Hold all request outputs stable until bus_gnt_i. A grant moves to RD_WAIT and drops req in the next cycle.
- RD_WAIT: on bus_rvalid_i, capture bus_rdata_i into the data register.
  - bus_err_i=1: set err_o, go to DONE.
  - Otherwise go to WR_REQ.
- WR_REQ: bus_req_o=1, bus_we_o=1, address = destination, bus_wdata_o = captured data, held until bus_gnt_i. A grant moves to WR_WAIT.
- WR_WAIT: on bus_rvalid_i:
  - bus_err_i=1: set err_o, go to DONE; count is not incremented.
  - Otherwise count_o++. If idx==31 go to DONE; else idx++ and go to RD_REQ.
- DONE: done_o=1 for exactly one cycle, then IDLE.
- Handshake and status:
  - At most one outstanding transaction.
  - bus_rvalid_i outside RD_WAIT/WR_WAIT is ignored.
  - gnt and rvalid in the same cycle in REQ states: the rvalid is ignored, since responses arrive no earlier than the cycle after grant.
  - busy_o = (state != IDLE), including DONE.
- Latency: with gnt tied high and rvalid one cycle after grant, each word takes 4 cycles. start_i at edge N gives done_o high in cycle N+125 and busy_o low from N+126.
- Reset mid-operation: immediately returns to the reset state and drops bus_req_o. Any outstanding response arriving afterwards is ignored.

Optional Feature:
- Macro: AXUM_CTX_COPY_ABORT_EN.
- Defined: adds input abort_i (1 bit).
  - In IDLE or DONE, abort_i is ignored.
  - In a REQ state without grant in the same cycle: drop req, set err_o, go to DONE next cycle.
  - In a REQ state with grant in the same cycle, or in a WAIT state: wait for bus_rvalid_i (data not used further), then set err_o and go to DONE.
  - count_o keeps the words completed before the abort.
- Not defined: no abort_i port; an operation always runs to completion or to a bus error.

Test Plan:
- Save, ctx=2, mem_addr_i=0x1000, gnt=1, zero-wait responder with RF word k = 0xA000_0000+k -> reads at 0x2_0104..0x2_017C; writes mem 0x1004..0x107C with matching data; done_o at cycle 125; count_o=31; err_o=0.
- Restore, ctx=1, mem_addr_i=0x2000, mem word k = k*3 -> writes 0x2_0084..0x2_00FC with k*3; no access to x0 addresses 0x2_0080 or 0x2000.
- Random gnt stalls of 0-5 cycles -> request outputs stable while req && !gnt; same final data; count_o=31.
- bus_err_i on read of idx 5 (save) -> no write to mem+0x14; err_o=1; count_o=4; done_o pulses once; next start clears err_o.
- start_i pulsed while busy, plus stray rvalid in RD_REQ -> both ignored; sequence identical to baseline.
- rst_ni low during WR_WAIT of idx 10 -> bus_req_o=0, busy_o=0, count_o=0 asynchronously; late rvalid ignored.
